team_06_effect_engine: RTL and testbench
========================================

# team_06_effect_engine

Sample-rate audio effect processor that sits directly downstream of the team_06 control FSM and applies the selected effect to the outgoing microphone stream. It consumes the FSM's `current_effect` code and `effect_en` gate, processes one 8-bit offset-binary sample per `samp_valid` strobe, and produces the transmit sample plus a one-cycle `out_valid`. It holds a circular delay line for the echo and reverb effects and a triangle LFO for tremolo.

## Interface
- `DEPTH`, 1024: delay-line length in samples (power of two, ≥4); sets the echo/reverb delay.
- `TREM_DIV`, 16: accepted samples per LFO step (≥1).
- `clk`  in  1  system clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `samp_valid`  in  1  one-cycle strobe marking a new `samp_in`.
- `samp_in`  in  8  mic sample, unsigned, midpoint 128.
- `effect_en`  in  1  1 = process, 0 = bypass.
- `current_effect`  in  3  000 NORMAL, 001 ECHO, 010 TREMOLO, 011 REVERB, 100 SOFT; 101/110/111 treated as NORMAL.
- `samp_out`  out  8  processed sample, unsigned, midpoint 128.
- `out_valid`  out  1  one-cycle pulse, `samp_out` updated.
- `overrun`  out  1  sticky; a strobe arrived while busy.

## Operation
- FSM: IDLE → READ → CALC → OUT → IDLE. Only IDLE accepts `samp_valid`.
  - IDLE: on strobe, register `samp_in`, `current_effect` and `effect_en`; present read address `wptr`.
  - READ: the synchronous memory returns `d_raw`.
  - CALC: compute the result and register it into `samp_out`.
  - OUT: `out_valid` = 1. Write the delay line at `wptr`, then do `wptr` = (`wptr` + 1) mod `DEPTH` and `fill` = min(`fill` + 1, `DEPTH`).
- A strobe seen in READ, CALC or OUT is dropped and sets `overrun`, which stays 1 until reset.
- Arithmetic:
  - s = `samp_in` − 128 (9-bit signed).
  - d = `d_raw` as signed 8-bit, or 0 while `fill` < `DEPTH`.
  - All shifts are arithmetic.
  - Result y is saturated to [−128, 127], and `samp_out` = y + 128.
- Effects:
  - NORMAL: y = s.
  - SOFT: y = s >>> 1.
  - ECHO: y = s + (d >>> 1). Writes the dry s (8-bit) into the delay line.
  - REVERB: y = s + (d >>> 1). Writes the saturated y into the delay line (feedback).
  - TREMOLO: y = (s × g) >>> 8, where g = 128 + (`lfo` >> 1), range 128..255.
  - NORMAL, SOFT and TREMOLO also write the dry s, so the line stays warm.
- LFO (TREMOLO only):
  - A divider counts accepted TREMOLO samples. On reaching `TREM_DIV` − 1 it wraps to 0 and steps `lfo` by ±1.
  - `lfo` is an 8-bit triangle: it rises from 0 and reverses at 255; it falls and reverses at 0. It starts rising.
  - The LFO holds its value during other effects.
- Effect change: when the latched `current_effect` differs from the previous accepted sample's value, clear `fill`, the divider and `lfo` (direction rising) before the computation. Stale delay contents are therefore never mixed.
- Bypass (latched `effect_en` = 0):
  - y = s, with the same pipeline, latency and `out_valid` pulse.
  - No memory write; `wptr`, `fill` and the LFO hold.
  - The change-detect register still updates.
- Delay-line contents are not reset; the `fill` gating makes them don't-care.

## Timing
- Reset (`nrst` low, asynchronous):
  - Outputs: `samp_out` = 128, `out_valid` = 0, `overrun` = 0.
  - Internal state: FSM = IDLE, `wptr` = 0, `fill` = 0, divider = 0, `lfo` = 0 (rising), previous effect = NORMAL.
- Latency: with `samp_valid` high in cycle 0, `out_valid` = 1 in cycle 3 and `samp_out` changes at the start of cycle 3 and holds until the next OUT.
- The earliest next accepted strobe is cycle 4, so strobes must be spaced ≥4 cycles apart.
- Reset asserted mid-pipeline aborts the sample: no `out_valid`, no write.
- `wptr` wraps from `DEPTH` − 1 to 0. The read at `wptr` returns the sample written `DEPTH` accepted samples earlier.
- `fill` saturates at `DEPTH`.
- `current_effect` and `effect_en` are sampled only in IDLE on the strobe; changes mid-pipeline do not affect the sample in flight.

## Test plan
- Reset and bypass: pulse `nrst` low → `samp_out` = 128, `out_valid` = 0, `overrun` = 0. Then with `effect_en` = 0, strobe `samp_in` = 200 in cycle 0 → `out_valid` in cycle 3 and `samp_out` = 200.
- SOFT: `samp_in` = 200 → 164; `samp_in` = 0 → 64; `samp_in` = 128 → 128.
- ECHO (`DEPTH` = 4): feed 228, 128, 128, 128 → outputs equal the inputs (`fill` < 4). Then 128 → 178. Saturation: feed 255, 128, 128, 128, then 255 → 255.
- REVERB (`DEPTH` = 4): feed 228, 128, 128, 128, 128 → last output 178. Three more 128 samples, then 128 → 153.
- TREMOLO (`TREM_DIV` = 1): first sample 228 → 178 (g = 128). Drive 300 samples → `lfo` peaks at 255 then falls, with g never exceeding 255.
- Overrun and effect change: strobes in cycles 0 and 2 → exactly one `out_valid`, and `overrun` = 1 until reset. After ≥4 ECHO samples, switch to SOFT for one sample and back to ECHO → the next 4 ECHO outputs equal their inputs.

Source files
------------

// File: rtl/team_06_effect_engine.sv
// team_06_effect_engine: per-sample echo/reverb/tremolo/soft effect processor with a circular delay line and triangle LFO
module team_06_effect_engine #(
  parameter int DEPTH    = 1024,
  parameter int TREM_DIV = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       samp_valid,
  input  logic [7:0] samp_in,
  input  logic       effect_en,
  input  logic [2:0] current_effect,
  output logic [7:0] samp_out,
  output logic       out_valid,
  output logic       overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = TREM_DIV > 1 ? $clog2(TREM_DIV) : 1;
  localparam logic [2:0] E_NORM = 3'd0, E_TREM = 3'd2, E_REV = 3'd3, E_SOFT = 3'd4;
  typedef enum logic [1:0] {IDLE, READ, CALC, OUT} state_t;
  state_t state_q, state_d;
  logic [7:0] in_q, in_d, out_q, out_d, lfo_q, lfo_d, rd_q;
  logic signed [7:0] wdat_q, wdat_d, ysat, d;
  logic [2:0] eff_q, eff_d, prev_q, prev_d;
  logic en_q, en_d, dir_q, dir_d, ovr_q, ovr_d, we, flip, div_wrap;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0] fill_q, fill_d;
  logic [DW-1:0] div_q, div_d;
  logic signed [8:0] s;
  logic [8:0] g;
  logic signed [17:0] prod, y;
  logic [7:0] mem [DEPTH];
  always_comb begin
    s = $signed({1'b0, in_q}) - 9'sd128;
    d = fill_q[AW] ? $signed(rd_q) : 8'sd0;
    g = {2'b01, lfo_q[7:1]};
    prod = 18'(s) * $signed(18'(g));
    y = (!en_q || eff_q == E_NORM) ? 18'(s)
      : eff_q == E_SOFT ? 18'(s >>> 1)
      : eff_q == E_TREM ? prod >>> 8
      : 18'(s) + 18'(d >>> 1);
    ysat = y > 18'sd127 ? 8'h7f : y < -18'sd128 ? 8'h80 : y[7:0];
    div_wrap = div_q == DW'(TREM_DIV - 1);
    flip = dir_q ? lfo_q == 8'd0 : lfo_q == 8'hff;
    state_d = state_q;
    in_d = in_q;
    eff_d = eff_q;
    en_d = en_q;
    prev_d = prev_q;
    out_d = out_q;
    wdat_d = wdat_q;
    wptr_d = wptr_q;
    fill_d = fill_q;
    div_d = div_q;
    lfo_d = lfo_q;
    dir_d = dir_q;
    ovr_d = ovr_q | (samp_valid && state_q != IDLE);
    we = state_q == OUT && en_q;
    unique case (state_q)
      IDLE: if (samp_valid) begin
        state_d = READ;
        in_d = samp_in;
        eff_d = current_effect > 3'd4 ? E_NORM : current_effect;
        en_d = effect_en;
      end
      READ: begin
        state_d = CALC;
        prev_d = eff_q;
        if (en_q && eff_q != prev_q) begin
          fill_d = '0;
          div_d = '0;
          lfo_d = '0;
          dir_d = 1'b0;
        end
      end
      CALC: begin
        state_d = OUT;
        out_d = {~ysat[7], ysat[6:0]};
        wdat_d = eff_q == E_REV ? ysat : s[7:0];
      end
      OUT: begin
        state_d = IDLE;
        if (en_q) begin
          wptr_d = wptr_q + 1'b1;
          fill_d = fill_q[AW] ? fill_q : fill_q + 1'b1;
          if (eff_q == E_TREM) begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
            if (div_wrap) begin
              dir_d = dir_q ^ flip;
              lfo_d = (dir_q ^ flip) ? lfo_q - 8'd1 : lfo_q + 8'd1;
            end
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      in_q <= '0;
      eff_q <= E_NORM;
      en_q <= 1'b0;
      prev_q <= E_NORM;
      out_q <= 8'd128;
      wdat_q <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      div_q <= '0;
      lfo_q <= '0;
      dir_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q <= in_d;
      eff_q <= eff_d;
      en_q <= en_d;
      prev_q <= prev_d;
      out_q <= out_d;
      wdat_q <= wdat_d;
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      div_q <= div_d;
      lfo_q <= lfo_d;
      dir_q <= dir_d;
      ovr_q <= ovr_d;
    end
  end
  // delay line has no reset; fill gating masks stale contents
  always_ff @(posedge clk) begin
    if (we) mem[wptr_q] <= wdat_q;
    rd_q <= mem[wptr_q];
  end
  assign samp_out = out_q;
  assign out_valid = state_q == OUT;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_team_06_effect_engine.sv
// tb_team_06_effect_engine: directed plus randomized checks against a history-based reference model
module tb_team_06_effect_engine;
  localparam int DEPTH = 4, TREM_DIV = 1;
  logic clk = 0, nrst = 0, samp_valid = 0, effect_en = 0, out_valid, overrun;
  logic [7:0] samp_in = 0, samp_out;
  logic [2:0] current_effect = 0;
  int n_cmp = 0, n_bad = 0, fill_m = 0, tcnt = 0, prev_m = 0, last_out = 128;
  bit ov_m = 0;
  int hist[$];
  always #5 clk = ~clk;
  team_06_effect_engine #(.DEPTH(DEPTH), .TREM_DIV(TREM_DIV)) dut (
    .clk(clk), .nrst(nrst), .samp_valid(samp_valid), .samp_in(samp_in),
    .effect_en(effect_en), .current_effect(current_effect),
    .samp_out(samp_out), .out_valid(out_valid), .overrun(overrun)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  // d is the value written DEPTH enabled samples ago, valid once DEPTH samples share the current effect
  task automatic model(input int in_v, input int eff_v, input bit en_v, output int exp_v);
    int e, s, d, y, g, n, lfo;
    e = eff_v > 4 ? 0 : eff_v;
    if (en_v && e != prev_m) begin
      fill_m = 0;
      tcnt = 0;
    end
    prev_m = e;
    s = in_v - 128;
    d = fill_m >= DEPTH ? hist[0] : 0;
    n = (tcnt / TREM_DIV) % 510;
    lfo = n <= 255 ? n : 510 - n;
    g = 128 + lfo / 2;
    if (!en_v) y = s;
    else if (e == 4) y = s >>> 1;
    else if (e == 2) y = (s * g) >>> 8;
    else if (e == 1 || e == 3) y = s + (d >>> 1);
    else y = s;
    y = y > 127 ? 127 : y < -128 ? -128 : y;
    exp_v = y + 128;
    if (en_v) begin
      hist.push_back(e == 3 ? y : s);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      fill_m = fill_m < DEPTH ? fill_m + 1 : DEPTH;
      if (e == 2) tcnt++;
    end
  endtask
  task automatic step(input int in_v, input int eff_v, input bit en_v);
    int exp_v;
    model(in_v, eff_v, en_v, exp_v);
    @(negedge clk);
    samp_in = in_v[7:0];
    current_effect = eff_v[2:0];
    effect_en = en_v;
    samp_valid = 1;
    @(negedge clk);
    samp_valid = 0;
    current_effect = 3'($urandom);
    effect_en = 1'($urandom);
    samp_in = 8'($urandom);
    check("lat1_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("lat2_valid", 32'(out_valid), 0);
    check("hold_out", 32'(samp_out), last_out);
    @(negedge clk);
    check("out_valid", 32'(out_valid), 1);
    check("samp_out", 32'(samp_out), exp_v);
    check("overrun", 32'(overrun), 32'(ov_m));
    last_out = exp_v;
  endtask
  initial begin
    int e, pulses, got, eff, len;
    #12;
    check("rst_out", 32'(samp_out), 128);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ovr", 32'(overrun), 0);
    @(negedge clk);
    nrst = 1;
    step(200, 1, 0);
    step(200, 4, 1);
    step(0, 4, 1);
    step(128, 4, 1);
    step(228, 1, 1);
    repeat (3) step(128, 1, 1);
    step(128, 1, 1);
    step(255, 1, 1);
    repeat (3) step(128, 1, 1);
    step(255, 1, 1);
    step(228, 3, 1);
    repeat (4) step(128, 3, 1);
    repeat (3) step(128, 3, 1);
    step(128, 3, 1);
    step(228, 2, 1);
    repeat (300) step($urandom_range(0, 255), 2, 1);
    model(90, 0, 1, e);
    @(negedge clk);
    samp_in = 8'd90;
    current_effect = 3'd0;
    effect_en = 1;
    samp_valid = 1;
    pulses = 0;
    got = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      samp_valid = (c == 2);
      if (c == 2) samp_in = 8'd10;
      if (out_valid) begin
        pulses++;
        got = int'(samp_out);
      end
    end
    ov_m = 1;
    last_out = e;
    check("ovr_pulses", 32'(pulses), 1);
    check("ovr_out", 32'(got), 32'(e));
    check("ovr_sticky", 32'(overrun), 1);
    repeat (5) step($urandom_range(0, 255), 1, 1);
    step($urandom_range(0, 255), 4, 1);
    repeat (4) step($urandom_range(0, 255), 1, 1);
    for (int b = 0; b < 40; b++) begin
      eff = $urandom_range(0, 7);
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) step($urandom_range(0, 255), eff, $urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    samp_in = 8'd200;
    current_effect = 3'd1;
    effect_en = 1;
    samp_valid = 1;
    @(negedge clk);
    samp_valid = 0;
    nrst = 0;
    #1;
    check("abort_out", 32'(samp_out), 128);
    check("abort_valid", 32'(out_valid), 0);
    check("abort_ovr", 32'(overrun), 0);
    @(negedge clk);
    nrst = 1;
    fill_m = 0;
    tcnt = 0;
    prev_m = 0;
    ov_m = 0;
    last_out = 128;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 0);
    end
    repeat (6) step($urandom_range(0, 255), 1, 1);
    repeat (6) step($urandom_range(0, 255), 3, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
